// File: rtl/rvx_timer_scheduler_pkg.sv
// Shared definitions for the RVX timer scheduler: command opcodes, FSM
// states, time widths and the wrap-safe deadline comparison.
package rvx_timer_scheduler_pkg;

  localparam int TIME_W   = 64;
  localparam int PERIOD_W = 32;

  typedef enum logic [1:0] {
    OP_ARM    = 2'd0,
    OP_CANCEL = 2'd1,
    OP_ACK    = 2'd2,
    OP_NOP    = 2'd3
  } cmd_op_e;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } fsm_state_e;

  // A deadline is reached when (now - deadline) is non-negative as a signed
  // 64-bit value; this stays correct across wrap of the timer count.
  function automatic logic deadline_reached(input logic [TIME_W-1:0] now,
                                            input logic [TIME_W-1:0] deadline);
    logic signed [TIME_W-1:0] diff;
    diff = signed'(now - deadline);
    return ~diff[TIME_W-1];
  endfunction

endpackage

// File: rtl/rvx_timer_slot_bank.sv
// Deadline slot storage: NUM_SLOTS x {enabled, deadline, period}.
// One command write port (ARM/CANCEL), one scanner read/update port and an
// INIT clear port. A command to the slot under scan suppresses the scanner
// update for that slot and reports it through o_scan_blocked.
module rvx_timer_slot_bank
  import rvx_timer_scheduler_pkg::*;
#(
  parameter int NUM_SLOTS = 4,
  parameter int SLOT_W    = 2
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                i_clr_en,
  input  logic [SLOT_W-1:0]   i_clr_slot,
  input  logic                i_wr_en,
  input  logic                i_wr_arm,
  input  logic [SLOT_W-1:0]   i_wr_slot,
  input  logic [TIME_W-1:0]   i_wr_deadline,
  input  logic [PERIOD_W-1:0] i_wr_period,
  input  logic [SLOT_W-1:0]   i_scan_slot,
  input  logic                i_scan_expire,
  output logic                o_scan_enabled,
  output logic [TIME_W-1:0]   o_scan_deadline,
  output logic                o_scan_blocked
);

  logic                r_enabled  [NUM_SLOTS];
  logic [TIME_W-1:0]   r_deadline [NUM_SLOTS];
  logic [PERIOD_W-1:0] r_period   [NUM_SLOTS];

  logic w_blocked;

  assign w_blocked       = i_wr_en && (i_wr_slot == i_scan_slot);
  assign o_scan_blocked  = w_blocked;
  assign o_scan_enabled  = r_enabled[i_scan_slot];
  assign o_scan_deadline = r_deadline[i_scan_slot];

  // Slot state update: INIT clear, then scanner re-arm/disable, then command write (command wins).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        r_enabled[i]  <= 1'b0;
        r_deadline[i] <= '0;
        r_period[i]   <= '0;
      end
    end else if (i_clr_en) begin
      r_enabled[i_clr_slot]  <= 1'b0;
      r_deadline[i_clr_slot] <= '0;
      r_period[i_clr_slot]   <= '0;
    end else begin
      if (i_scan_expire && !w_blocked) begin
        if (r_period[i_scan_slot] != '0)
          r_deadline[i_scan_slot] <= r_deadline[i_scan_slot] + TIME_W'(r_period[i_scan_slot]);
        else
          r_enabled[i_scan_slot] <= 1'b0;
      end
      if (i_wr_en) begin
        r_enabled[i_wr_slot] <= i_wr_arm;
        if (i_wr_arm) begin
          r_deadline[i_wr_slot] <= i_wr_deadline;
          r_period[i_wr_slot]   <= i_wr_period;
        end
      end
    end
  end

endmodule

// File: rtl/rvx_timer_scheduler.sv
// RVX timer scheduler: multiplexes NUM_SLOTS software deadlines onto mtime.
// A round-robin scanner tests one slot per cycle; expiries latch into
// pending (with sticky overrun), and irq replaces the mtimecmp interrupt.
module rvx_timer_scheduler
  import rvx_timer_scheduler_pkg::*;
#(
  parameter int NUM_SLOTS = 4,
  parameter int SLOT_W    = 2
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [TIME_W-1:0]    mtime,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [SLOT_W-1:0]    cmd_slot,
  input  logic [TIME_W-1:0]    cmd_deadline,
  input  logic [PERIOD_W-1:0]  cmd_period,
  input  logic [NUM_SLOTS-1:0] cmd_mask,
  input  logic [NUM_SLOTS-1:0] irq_enable,
  output logic [NUM_SLOTS-1:0] pending,
  output logic [NUM_SLOTS-1:0] overrun,
  output logic                 irq
);

  fsm_state_e           r_state;
  logic [SLOT_W-1:0]    r_init_idx;
  logic [SLOT_W-1:0]    r_ptr;
  logic                 r_cmd_ready;
  logic [NUM_SLOTS-1:0] r_pending;
  logic [NUM_SLOTS-1:0] r_overrun;

  cmd_op_e              w_op;
  logic                 w_accept;
  logic                 w_wr_en;
  logic                 w_ack;
  logic                 w_run;
  logic                 w_scan_enabled;
  logic [TIME_W-1:0]    w_scan_deadline;
  logic                 w_scan_blocked;
  logic                 w_expire;
  logic [NUM_SLOTS-1:0] w_set;
  logic [NUM_SLOTS-1:0] w_clr;

  assign w_op     = cmd_op_e'(cmd_op);
  assign w_accept = cmd_valid && r_cmd_ready;
  assign w_wr_en  = w_accept && ((w_op == OP_ARM) || (w_op == OP_CANCEL));
  assign w_ack    = w_accept && (w_op == OP_ACK);
  assign w_run    = (r_state == ST_RUN);
  assign w_expire = w_run && w_scan_enabled && !w_scan_blocked
                    && deadline_reached(mtime, w_scan_deadline);
  assign w_clr    = w_ack ? cmd_mask : '0;

  rvx_timer_slot_bank #(
    .NUM_SLOTS (NUM_SLOTS),
    .SLOT_W    (SLOT_W)
  ) u_bank (
    .clock           (clock),
    .reset_n         (reset_n),
    .i_clr_en        (!w_run),
    .i_clr_slot      (r_init_idx),
    .i_wr_en         (w_wr_en),
    .i_wr_arm        (w_op == OP_ARM),
    .i_wr_slot       (cmd_slot),
    .i_wr_deadline   (cmd_deadline),
    .i_wr_period     (cmd_period),
    .i_scan_slot     (r_ptr),
    .i_scan_expire   (w_expire),
    .o_scan_enabled  (w_scan_enabled),
    .o_scan_deadline (w_scan_deadline),
    .o_scan_blocked  (w_scan_blocked)
  );

  // One-hot set vector for the slot currently under scan.
  always_comb begin
    w_set = '0;
    if (w_expire) w_set[r_ptr] = 1'b1;
  end

  // INIT/RUN FSM: INIT walks every slot once, RUN advances the scan pointer each cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_INIT;
      r_init_idx  <= '0;
      r_ptr       <= '0;
      r_cmd_ready <= 1'b0;
    end else if (r_state == ST_INIT) begin
      if (r_init_idx == SLOT_W'(NUM_SLOTS - 1)) begin
        r_state     <= ST_RUN;
        r_cmd_ready <= 1'b1;
      end else begin
        r_init_idx <= r_init_idx + 1'b1;
      end
    end else begin
      r_ptr <= r_ptr + 1'b1;
    end
  end

  // Pending/overrun: an expiry beats a same-cycle ACK, but that expiry does not count as an overrun.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pending <= '0;
      r_overrun <= '0;
    end else begin
      r_pending <= w_set | (r_pending & ~w_clr);
      r_overrun <= (r_overrun & ~w_clr) | (w_set & r_pending & ~w_clr);
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign pending   = r_pending;
  assign overrun   = r_overrun;
  assign irq       = |(r_pending & irq_enable);

endmodule
